persiana_motor_drv: RTL and testbench

Motor-driver stage for the automatic blind (persiana). It sits directly downstream of the blind FSM and consumes its `subir`/`bajar` commands. It converts them into safe H-bridge drive signals: direction-change dead time, soft-start PWM ramp, brake interval, travel-limit interlock and run-timeout fault. It runs on the fast system clock, not the prescaled FSM clock.

---
 rtl/persiana_pkg.sv | 19 +
 rtl/persiana_motor_drv_if.sv | 25 ++
 rtl/persiana_pwm.sv | 54 +++++
 rtl/persiana_motor_drv.sv | 124 ++++++++++++
 tb/tb_persiana_motor_drv.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/persiana_pkg.sv
// Shared types for the blind motor-driver slice: FSM states, direction
// encoding and the effective-command decode.
package persiana_pkg;

  typedef enum logic [2:0] {IDLE, DEAD, RAMP, RUN, BRAKE, FAULT} state_t;
  typedef enum logic [1:0] {STOP, UP, DN} cmd_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Conflicting requests, or a request into its own end-stop, collapse to STOP.
  function automatic cmd_t decode_cmd(input logic subir, input logic bajar,
                                      input logic lim_sup, input logic lim_inf);
    if (subir && !bajar && !lim_sup)      return UP;
    else if (bajar && !subir && !lim_inf) return DN;
    else                                  return STOP;
  endfunction

endpackage

// File: rtl/persiana_motor_drv_if.sv
// Command/limit inputs and H-bridge outputs between the blind controller
// (master) and the motor driver (slave).
interface persiana_motor_drv_if;

  logic subir;
  logic bajar;
  logic lim_sup;
  logic lim_inf;
  logic mot_up;
  logic mot_dn;
  logic freno;
  logic fault;
  logic busy;

  modport master (
    output subir, bajar, lim_sup, lim_inf,
    input  mot_up, mot_dn, freno, fault, busy
  );

  modport slave (
    input  subir, bajar, lim_sup, lim_inf,
    output mot_up, mot_dn, freno, fault, busy
  );

endinterface

// File: rtl/persiana_pwm.sv
// Soft-start PWM: free-running period counter, saturating duty ramp and
// compare. Held cleared by the FSM outside RAMP, advanced only in RAMP.
module persiana_pwm #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic clk,
  input  logic reseteo,
  input  logic clear,
  input  logic enable,
  output logic pwm_on,
  output logic wrap,
  output logic duty_full
);

  localparam int FULL = 1 << PWM_BITS;
  localparam logic [PWM_BITS:0] DUTY_FULL = (PWM_BITS+1)'(FULL);
  localparam logic [PWM_BITS:0] DUTY_INIT =
    (RAMP_STEP >= FULL) ? DUTY_FULL : (PWM_BITS+1)'(RAMP_STEP);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS:0]   duty_q, duty_d, duty_inc;
  logic [PWM_BITS+1:0] duty_sum;

  // One extra bit on the sum so the step never wraps before saturation.
  assign duty_sum  = {1'b0, duty_q} + (PWM_BITS+2)'(RAMP_STEP);
  assign duty_inc  = (duty_sum >= (PWM_BITS+2)'(FULL)) ? DUTY_FULL : duty_sum[PWM_BITS:0];
  assign wrap      = enable && (cnt_q == '1);
  assign duty_full = wrap && (duty_inc == DUTY_FULL);
  assign pwm_on    = ({1'b0, cnt_q} < duty_q);

  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (clear) begin
      cnt_d  = '0;
      duty_d = DUTY_INIT;
    end else if (enable) begin
      cnt_d = cnt_q + PWM_BITS'(1);
      if (wrap) duty_d = duty_inc;
    end
  end

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

endmodule

// File: rtl/persiana_motor_drv.sv
// H-bridge driver for the blind motor: dead time, soft-start ramp, brake,
// end-stop interlock and run-timeout fault on the fast system clock.
module persiana_motor_drv
  import persiana_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_STEP   = 16,
  parameter int DEAD_CYC    = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic                 clk,
  input logic                 reseteo,
  persiana_motor_drv_if.slave bus
);

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam int RW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYC - 1);
  localparam logic [RW-1:0] RUN_LIM = RW'(TIMEOUT_CYC);

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic          freno_q, fault_q, busy_q;
  cmd_t          cmd;
  logic          cmd_dir;
  logic          pwm_on, wrap, duty_full;
  logic          leg_on;

  assign cmd     = decode_cmd(bus.subir, bus.bajar, bus.lim_sup, bus.lim_inf);
  assign cmd_dir = (cmd == UP) ? DIR_UP : DIR_DN;
  assign run_inc = (run_q == '1) ? run_q : run_q + RW'(1);

  persiana_pwm #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_pwm (
    .clk       (clk),
    .reseteo   (reseteo),
    .clear     (state_q != RAMP),
    .enable    (state_q == RAMP),
    .pwm_on    (pwm_on),
    .wrap      (wrap),
    .duty_full (duty_full)
  );

  // Transition priority in RAMP/RUN: brake, then timeout, then ramp completion.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dcnt_d  = dcnt_q;
    run_d   = '0;
    case (state_q)
      IDLE: begin
        if (cmd != STOP) begin
          state_d = DEAD;
          dir_d   = cmd_dir;
          dcnt_d  = DEAD_LD;
        end
      end
      DEAD: begin
        if (cmd == STOP) begin
          state_d = IDLE;
        end else if (cmd_dir != dir_q) begin
          dir_d  = cmd_dir;
          dcnt_d = DEAD_LD;
        end else if (dcnt_q == '0) begin
          state_d = RAMP;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      RAMP, RUN: begin
        run_d = run_inc;
        if (cmd == STOP || cmd_dir != dir_q) begin
          state_d = BRAKE;
          dcnt_d  = DEAD_LD;
        end else if (run_inc >= RUN_LIM) begin
          state_d = FAULT;
        end else if (state_q == RAMP && wrap && duty_full) begin
          state_d = RUN;
        end
      end
      BRAKE: begin
        if (dcnt_q == '0) state_d = IDLE;
        else              dcnt_d  = dcnt_q - DW'(1);
      end
      FAULT: begin
        if (cmd == STOP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      state_q <= IDLE;
      dir_q   <= DIR_DN;
      dcnt_q  <= '0;
      run_q   <= '0;
      freno_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dcnt_q  <= dcnt_d;
      run_q   <= run_d;
      freno_q <= (state_d == BRAKE) || (state_d == FAULT);
      fault_q <= (state_d == FAULT);
      busy_q  <= (state_d != IDLE);
    end
  end

  // A single leg_on gated by one dir bit makes both legs high impossible.
  assign leg_on     = (state_q == RUN) || (state_q == RAMP && pwm_on);
  assign bus.mot_up = leg_on && (dir_q == DIR_UP);
  assign bus.mot_dn = leg_on && (dir_q == DIR_DN);
  assign bus.freno  = freno_q;
  assign bus.fault  = fault_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_persiana_motor_drv.sv
// Scoreboard bench for persiana_motor_drv: a phase/elapsed-time model predicts
// every cycle's outputs, a negedge monitor compares them.
module tb_persiana_motor_drv;

  localparam int PWM_BITS     = 4;
  localparam int RAMP_STEP    = 4;
  localparam int DEAD_CYC     = 3;
  localparam int TIMEOUT_CYC  = 200;
  localparam int PER          = 1 << PWM_BITS;
  localparam int RAMP_PERIODS = (PER + RAMP_STEP - 1) / RAMP_STEP - 1;

  logic clk = 1'b0;
  logic reseteo = 1'b1;
  always #5 clk = ~clk;

  persiana_motor_drv_if bus();

  persiana_motor_drv #(
    .PWM_BITS    (PWM_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_CYC    (DEAD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk     (clk),
    .reseteo (reseteo),
    .bus     (bus)
  );

  typedef struct packed {
    logic up;
    logic dn;
    logic fr;
    logic ft;
    logic bz;
  } outv_t;

  typedef enum int {M_IDLE, M_DEAD, M_RAMP, M_RUN, M_BRAKE, M_FAULT} mphase_t;

  outv_t   exp_q[$];
  int      checks = 0;
  int      errors = 0;
  mphase_t ph = M_IDLE;
  bit      mup = 1'b0;
  int      cnt = 0;
  int      run = 0;
  int      t = 0;

  // Outputs implied by the current phase; in RAMP, t is cycles since ramp start.
  function automatic outv_t model_out();
    outv_t o;
    bit leg;
    leg  = (ph == M_RUN) ||
           (ph == M_RAMP && (t % PER) < RAMP_STEP * (t / PER + 1));
    o.up = leg && mup;
    o.dn = leg && !mup;
    o.fr = (ph == M_BRAKE) || (ph == M_FAULT);
    o.ft = (ph == M_FAULT);
    o.bz = (ph != M_IDLE);
    return o;
  endfunction

  always @(posedge clk) begin : model
    int c;
    if (reseteo) begin
      ph = M_IDLE; cnt = 0; run = 0; t = 0;
    end else begin
      if (bus.subir && !bus.bajar && !bus.lim_sup)      c = 1;
      else if (bus.bajar && !bus.subir && !bus.lim_inf) c = 2;
      else                                              c = 0;
      case (ph)
        M_IDLE: if (c != 0) begin ph = M_DEAD; mup = (c == 1); cnt = 0; end
        M_DEAD: begin
          if (c == 0) ph = M_IDLE;
          else if ((c == 1) != mup) begin mup = (c == 1); cnt = 0; end
          else begin
            cnt++;
            if (cnt == DEAD_CYC) begin ph = M_RAMP; t = 0; run = 0; end
          end
        end
        M_RAMP, M_RUN: begin
          run++;
          if (c == 0 || (c == 1) != mup) begin ph = M_BRAKE; cnt = 0; end
          else if (run >= TIMEOUT_CYC) ph = M_FAULT;
          else if (ph == M_RAMP) begin
            t++;
            if (t >= RAMP_PERIODS * PER) ph = M_RUN;
          end
        end
        M_BRAKE: begin
          cnt++;
          if (cnt == DEAD_CYC) ph = M_IDLE;
        end
        M_FAULT: if (c == 0) ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end
    exp_q.push_back(model_out());
  end

  always @(negedge clk) begin : monitor
    outv_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.mot_up, bus.mot_dn, bus.freno, bus.fault, bus.busy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t {up,dn,freno,fault,busy} got=%b expected=%b", $time, a, e);
      end
      checks++;
      if (bus.mot_up && bus.mot_dn) begin
        errors++;
        $display("FAIL leg_overlap t=%0t got up=%b dn=%b expected not both 1", $time, bus.mot_up, bus.mot_dn);
      end
    end
  end

  task automatic hold(input logic s, input logic b, input logic ls, input logic li, input int n);
    bus.subir = s; bus.bajar = b; bus.lim_sup = ls; bus.lim_inf = li;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.subir = 1'b0; bus.bajar = 1'b0; bus.lim_sup = 1'b0; bus.lim_inf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reseteo = 1'b0;

    // Raise to RUN, release, brake to idle.
    hold(1, 0, 0, 0, 60);
    hold(0, 0, 0, 0, 6);
    // Raise to RUN, reverse: brake, idle, dead, lower ramp.
    hold(1, 0, 0, 0, 60);
    hold(0, 1, 0, 0, 70);
    hold(0, 0, 0, 0, 5);
    // Run into the timeout fault and clear it.
    hold(1, 0, 0, 0, 230);
    hold(0, 0, 0, 0, 3);
    // Lower blocked by the end-stop, then end-stop arriving mid-RUN.
    hold(0, 1, 0, 1, 10);
    hold(0, 1, 0, 0, 60);
    hold(0, 1, 0, 1, 5);
    hold(0, 0, 0, 0, 5);
    // Asynchronous reset in the middle of the ramp.
    hold(1, 0, 0, 0, 20);
    @(negedge clk);
    #2 reseteo = 1'b1;
    #1;
    checks++;
    if ({bus.mot_up, bus.mot_dn, bus.freno, bus.fault, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%b expected=00000",
               {bus.mot_up, bus.mot_dn, bus.freno, bus.fault, bus.busy});
    end
    @(posedge clk);
    @(posedge clk);
    #1 reseteo = 1'b0;
    hold(1, 0, 0, 0, 10);
    hold(0, 0, 0, 0, 5);

    for (int i = 0; i < 40; i++) begin
      int r;
      logic s, b;
      r = $urandom_range(0, 5);
      s = (r <= 1) || (r == 5);
      b = (r == 2) || (r == 3) || (r == 5);
      hold(s, b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(1, 90));
    end
    hold(0, 0, 0, 0, 10);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
